// File: rtl/traffic_light_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_monitor_pkg
// Description : Shared phase encodings and lamp-vector helpers for the
//               traffic-light lamp monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_light_monitor_pkg;

    // Phase encodings: also the values driven on o_phase.
    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_RED      = 3'd1,
        PH_YELLOW_1 = 3'd2,
        PH_GREEN    = 3'd3,
        PH_YELLOW_2 = 3'd4
    } phase_e;

    // Lamp vectors packed as {red, yellow, green}.
    localparam logic [2:0] C_LAMP_RED    = 3'b100;
    localparam logic [2:0] C_LAMP_YELLOW = 3'b010;
    localparam logic [2:0] C_LAMP_GREEN  = 3'b001;

    function automatic logic is_one_hot(input logic [2:0] lamp);
        return (lamp == C_LAMP_RED) || (lamp == C_LAMP_YELLOW) ||
               (lamp == C_LAMP_GREEN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : traffic_dwell_counter
// Description : Saturating dwell counter for one lamp phase. Clears to 0,
//               loads 1 on phase entry, increments while the lamp holds.
//               Compares the current count to the phase target.
// Ports       : i_clk, i_rst      clock, synchronous active-high reset
//               i_clear           force count to 0 (highest priority)
//               i_load_one        force count to 1 (new phase entered)
//               i_inc             same lamp sampled again: count + 1
//               i_target          required dwell of the current phase
//               o_match           count == target
//               o_overrun         increment requested while count == target
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_dwell_counter #(
    parameter int COUNT_WIDTH = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic                   i_load_one,
    input  logic                   i_inc,
    input  logic [COUNT_WIDTH-1:0] i_target,
    output logic                   o_match,
    output logic                   o_overrun
);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_load_one) begin
            count_d = COUNT_WIDTH'(1);
        end else if (i_inc && (count_q != '1)) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_match   = (count_q == i_target);
    // Only exactly-at-target flags an overrun, so it fires once per phase;
    // the count then moves past the target and stays there.
    assign o_overrun = i_inc && o_match;

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_monitor
// Description : Checks sampled traffic-light lamps against the legal cycle
//               RED -> YELLOW_1 -> GREEN -> YELLOW_2 -> RED and the configured
//               dwell times. Reports pattern/sequence/timing error pulses,
//               lock status, completed-cycle and error counts.
// Ports       : i_clk, i_rst                 clock, sync active-high reset
//               i_red, i_yellow, i_green     lamp samples
//               o_phase                      tracked phase (0..4)
//               o_locked                     verified legal sequence
//               o_err_pattern/seq/timing     1-cycle error pulses
//               o_cycle_cnt                  YELLOW_2->RED count, wraps
//               o_err_cnt                    error count, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_monitor
    import traffic_light_monitor_pkg::*;
#(
    parameter int GLOW_RED      = 10,
    parameter int GLOW_YELLOW_1 = 10,
    parameter int GLOW_GREEN    = 10,
    parameter int GLOW_YELLOW_2 = 10,
    parameter int COUNT_WIDTH   = 5,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_red,
    input  logic                 i_yellow,
    input  logic                 i_green,
    output logic [2:0]           o_phase,
    output logic                 o_locked,
    output logic                 o_err_pattern,
    output logic                 o_err_seq,
    output logic                 o_err_timing,
    output logic [CNT_WIDTH-1:0] o_cycle_cnt,
    output logic [CNT_WIDTH-1:0] o_err_cnt
);

    phase_e                 phase_q, phase_d;
    logic                   locked_q, locked_d;
    logic                   exempt_q, exempt_d;   // current phase timing-exempt
    logic                   ovr_q, ovr_d;         // overrun already reported
    logic                   err_pat_q, err_pat_d;
    logic                   err_seq_q, err_seq_d;
    logic                   err_tim_q, err_tim_d;
    logic [CNT_WIDTH-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

    logic [2:0]             w_lamp;
    logic [2:0]             w_hold_lamp;
    logic [2:0]             w_next_lamp;
    phase_e                 w_next_phase;
    logic [COUNT_WIDTH-1:0] w_target;
    logic                   w_clear, w_load_one, w_inc;
    logic                   w_match, w_overrun;
    logic                   w_dwell_ok;

    assign w_lamp = {i_red, i_yellow, i_green};

    // Per-phase lamp that keeps the phase, lamp that advances it, and target.
    always_comb begin
        w_hold_lamp  = 3'b000;
        w_next_lamp  = 3'b000;
        w_next_phase = PH_IDLE;
        w_target     = '0;
        case (phase_q)
            PH_RED: begin
                w_hold_lamp  = C_LAMP_RED;
                w_next_lamp  = C_LAMP_YELLOW;
                w_next_phase = PH_YELLOW_1;
                w_target     = COUNT_WIDTH'(GLOW_RED);
            end
            PH_YELLOW_1: begin
                w_hold_lamp  = C_LAMP_YELLOW;
                w_next_lamp  = C_LAMP_GREEN;
                w_next_phase = PH_GREEN;
                w_target     = COUNT_WIDTH'(GLOW_YELLOW_1);
            end
            PH_GREEN: begin
                w_hold_lamp  = C_LAMP_GREEN;
                w_next_lamp  = C_LAMP_YELLOW;
                w_next_phase = PH_YELLOW_2;
                w_target     = COUNT_WIDTH'(GLOW_GREEN);
            end
            PH_YELLOW_2: begin
                w_hold_lamp  = C_LAMP_YELLOW;
                w_next_lamp  = C_LAMP_RED;
                w_next_phase = PH_RED;
                w_target     = COUNT_WIDTH'(GLOW_YELLOW_2);
            end
            default: ;
        endcase
    end

    traffic_dwell_counter #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_dwell (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_clear),
        .i_load_one (w_load_one),
        .i_inc      (w_inc),
        .i_target   (w_target),
        .o_match    (w_match),
        .o_overrun  (w_overrun)
    );

    // Exempt phases count as correct; an overrun phase never does.
    assign w_dwell_ok = exempt_q || (w_match && !ovr_q);

    always_comb begin
        phase_d     = phase_q;
        locked_d    = locked_q;
        exempt_d    = exempt_q;
        ovr_d       = ovr_q;
        err_pat_d   = 1'b0;
        err_seq_d   = 1'b0;
        err_tim_d   = 1'b0;
        cycle_cnt_d = cycle_cnt_q;
        w_clear     = 1'b0;
        w_load_one  = 1'b0;
        w_inc       = 1'b0;

        if (!is_one_hot(w_lamp)) begin
            err_pat_d = 1'b1;
            phase_d   = PH_IDLE;
            locked_d  = 1'b0;
            ovr_d     = 1'b0;
            w_clear   = 1'b1;
        end else if (phase_q == PH_IDLE) begin
            // Yellow/green-only samples are ignored until red shows up.
            if (w_lamp == C_LAMP_RED) begin
                phase_d    = PH_RED;
                exempt_d   = 1'b1;
                ovr_d      = 1'b0;
                w_load_one = 1'b1;
            end
        end else if (w_lamp == w_hold_lamp) begin
            w_inc = 1'b1;
            if (w_overrun && !exempt_q && !ovr_q) begin
                err_tim_d = 1'b1;
                ovr_d     = 1'b1;
                locked_d  = 1'b0;
            end
        end else if (w_lamp == w_next_lamp) begin
            phase_d    = w_next_phase;
            exempt_d   = 1'b0;
            ovr_d      = 1'b0;
            w_load_one = 1'b1;
            if (!w_dwell_ok && !ovr_q) begin
                err_tim_d = 1'b1;
                locked_d  = 1'b0;
            end else if ((phase_q == PH_RED) && w_dwell_ok) begin
                locked_d = 1'b1;
            end
            if (phase_q == PH_YELLOW_2) begin
                cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
            end
        end else begin
            // Illegal transition: resync on red/green, drop to IDLE on yellow.
            err_seq_d = 1'b1;
            locked_d  = 1'b0;
            ovr_d     = 1'b0;
            exempt_d  = 1'b1;
            if (w_lamp == C_LAMP_RED) begin
                phase_d    = PH_RED;
                w_load_one = 1'b1;
            end else if (w_lamp == C_LAMP_GREEN) begin
                phase_d    = PH_GREEN;
                w_load_one = 1'b1;
            end else begin
                phase_d = PH_IDLE;
                w_clear = 1'b1;
            end
        end

        err_cnt_d = err_cnt_q;
        if ((err_pat_d || err_seq_d || err_tim_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_q     <= PH_IDLE;
            locked_q    <= 1'b0;
            exempt_q    <= 1'b0;
            ovr_q       <= 1'b0;
            err_pat_q   <= 1'b0;
            err_seq_q   <= 1'b0;
            err_tim_q   <= 1'b0;
            cycle_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            phase_q     <= phase_d;
            locked_q    <= locked_d;
            exempt_q    <= exempt_d;
            ovr_q       <= ovr_d;
            err_pat_q   <= err_pat_d;
            err_seq_q   <= err_seq_d;
            err_tim_q   <= err_tim_d;
            cycle_cnt_q <= cycle_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_phase       = phase_q;
    assign o_locked      = locked_q;
    assign o_err_pattern = err_pat_q;
    assign o_err_seq     = err_seq_q;
    assign o_err_timing  = err_tim_q;
    assign o_cycle_cnt   = cycle_cnt_q;
    assign o_err_cnt     = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_monitor
// Description : Directed self-checking bench for traffic_light_monitor with
//               default dwell of 10 cycles per phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] RG = 3'b101;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       red = 1'b0, yellow = 1'b0, green = 1'b0;
    logic [2:0] phase;
    logic       locked, err_pat, err_seq, err_tim;
    logic [7:0] cycle_cnt, err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int tot_pat  = 0;
    int tot_seq  = 0;
    int tot_tim  = 0;

    traffic_light_monitor dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_red         (red),
        .i_yellow      (yellow),
        .i_green       (green),
        .o_phase       (phase),
        .o_locked      (locked),
        .o_err_pattern (err_pat),
        .o_err_seq     (err_seq),
        .o_err_timing  (err_tim),
        .o_cycle_cnt   (cycle_cnt),
        .o_err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one lamp sample, let it be clocked in, then tally error pulses.
    task automatic step(input logic [2:0] lamp);
        {red, yellow, green} = lamp;
        @(posedge clk);
        #1;
        tot_pat += int'(err_pat);
        tot_seq += int'(err_seq);
        tot_tim += int'(err_tim);
    endtask

    task automatic hold(input logic [2:0] lamp, input int n);
        for (int i = 0; i < n; i++) step(lamp);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(R);
        rst = 1'b0;
        check_eq("rst_phase", phase, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_pulses", {err_pat, err_seq, err_tim}, 0);
        check_eq("rst_cycle", cycle_cnt, 0);
        check_eq("rst_errcnt", err_cnt, 0);

        // Two clean cycles
        hold(R, 10);
        check_eq("clean_red_phase", phase, 1);
        check_eq("clean_red_unlocked", locked, 0);
        step(Y);
        check_eq("clean_y1_phase", phase, 2);
        check_eq("clean_first_lock", locked, 1);
        hold(Y, 9); hold(G, 10); hold(Y, 10);
        hold(R, 10); hold(Y, 10); hold(G, 10); hold(Y, 10);
        step(R);
        check_eq("clean_cycle", cycle_cnt, 2);
        check_eq("clean_errcnt", err_cnt, 0);
        check_eq("clean_pulses", tot_pat + tot_seq + tot_tim, 0);
        check_eq("clean_locked", locked, 1);
        check_eq("clean_phase", phase, 1);

        // Red held 12 cycles: overrun only on the 11th sample
        hold(R, 9);
        check_eq("red10_no_tim", tot_tim, 0);
        step(R);
        check_eq("red11_tim", err_tim, 1);
        check_eq("red11_errcnt", err_cnt, 1);
        check_eq("red11_locked", locked, 0);
        step(R);
        check_eq("red12_no_tim", err_tim, 0);
        step(Y);
        check_eq("red_to_y_no_tim", err_tim, 0);
        check_eq("red_to_y_phase", phase, 2);
        check_eq("red_to_y_no_relock", locked, 0);
        check_eq("red_to_y_errcnt", err_cnt, 1);

        // Green held 9 then yellow
        hold(Y, 9); hold(G, 9);
        step(Y);
        check_eq("green9_tim", err_tim, 1);
        check_eq("green9_errcnt", err_cnt, 2);
        check_eq("green9_phase", phase, 4);

        // Green -> red directly, then a clean relocking cycle
        hold(Y, 9); hold(R, 10);
        check_eq("seq_pre_cycle", cycle_cnt, 3);
        step(Y);
        check_eq("seq_pre_lock", locked, 1);
        hold(Y, 9); hold(G, 5);
        step(R);
        check_eq("g2r_seq", err_seq, 1);
        check_eq("g2r_phase", phase, 1);
        check_eq("g2r_locked", locked, 0);
        check_eq("g2r_errcnt", err_cnt, 3);
        hold(R, 4);
        step(Y);
        check_eq("resync_relock", locked, 1);
        hold(Y, 9); hold(G, 10); hold(Y, 10);
        step(R);
        check_eq("resync_cycle", cycle_cnt, 4);
        check_eq("resync_errcnt", err_cnt, 3);
        check_eq("resync_tim_total", tot_tim, 2);
        check_eq("resync_seq_total", tot_seq, 1);

        // Red -> green directly: resync to exempt GREEN
        hold(R, 9);
        step(G);
        check_eq("r2g_seq", err_seq, 1);
        check_eq("r2g_phase", phase, 3);
        hold(G, 14);
        step(Y);
        check_eq("exempt_green_no_tim", tot_tim, 2);
        check_eq("exempt_green_phase", phase, 4);
        check_eq("r2g_errcnt", err_cnt, 4);

        // Pattern errors and saturation
        step(RG);
        check_eq("pat_pulse", err_pat, 1);
        check_eq("pat_phase", phase, 0);
        check_eq("pat_locked", locked, 0);
        check_eq("pat_errcnt", err_cnt, 5);
        hold(RG, 300);
        check_eq("pat_saturate", err_cnt, 255);
        step(Y);
        check_eq("idle_yellow_phase", phase, 0);
        check_eq("idle_yellow_no_err", {err_pat, err_seq, err_tim}, 0);
        check_eq("idle_yellow_errcnt", err_cnt, 255);

        // Reset mid-GREEN
        rst = 1'b1;
        step(R);
        rst = 1'b0;
        hold(R, 10); hold(Y, 10); hold(G, 3);
        check_eq("midg_phase_pre", phase, 3);
        rst = 1'b1;
        step(G);
        rst = 1'b0;
        check_eq("midg_phase", phase, 0);
        check_eq("midg_locked", locked, 0);
        check_eq("midg_pulses", {err_pat, err_seq, err_tim}, 0);
        check_eq("midg_cycle", cycle_cnt, 0);
        check_eq("midg_errcnt", err_cnt, 0);
        step(G);
        check_eq("post_rst_idle", phase, 0);
        check_eq("post_rst_no_err", {err_pat, err_seq, err_tim}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
